// File: rtl/png_pkg.sv
// Shared definitions for the PNG pixel framer: FIFO entry layout and FSM encodings.
package png_pkg;
  localparam int ENTRY_W  = 35;
  localparam int DATA_MSB = 31;
  localparam int SOF_BIT  = 32;
  localparam int EOL_BIT  = 33;
  localparam int EOF_BIT  = 34;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/png_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a pop frees room for a same-cycle push when full.
module png_sync_fifo #(
  parameter int W  = 35,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/png_pixel_framer.sv
// Tags decoded pixels with SOF/EOL/EOF from the image geometry and queues them onto a stream.
// state     | meaning
// ST_IDLE   | no image open; arriving pixels are dropped and flagged as extra
// ST_ACTIVE | image open; pixels are tagged by (x,y) position and queued
module png_pixel_framer
  import png_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pstart,
  input  logic [2:0]  colortype,
  input  logic [13:0] width,
  input  logic [31:0] height,
  input  logic        pvalid,
  input  logic [7:0]  pr,
  input  logic [7:0]  pg,
  input  logic [7:0]  pb,
  input  logic [7:0]  pa,
  output logic        tvalid,
  input  logic        tready,
  output logic [31:0] tdata,
  output logic        tuser,
  output logic        tlast,
  output logic        teof,
  output logic [2:0]  ocolortype,
  output logic        busy,
  output logic        overflow,
  output logic        extra
);
  state_t       state, state_n;
  logic [13:0]  x_r, x_n, w_r, w_n, geo_w, cur_x;
  logic [31:0]  y_r, y_n, h_r, h_n, geo_h, cur_y;
  logic [2:0]   ct_r, ct_n;
  logic         ovf_r, ovf_n, extra_r, extra_n;
  logic         live, take, sof, eol, eof;

  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [FIFO_AW:0]   fifo_count;

  // pstart overrides the latched geometry so a same-cycle pixel belongs to the new image
  always_comb begin
    geo_w = w_r;
    geo_h = h_r;
    cur_x = x_r;
    cur_y = y_r;
    live  = (state == ST_ACTIVE);
    if (pstart) begin
      geo_w = width;
      geo_h = height;
      cur_x = '0;
      cur_y = '0;
      live  = (width != '0) && (height != '0);
    end
    take = pvalid && live;
    sof  = (cur_x == '0) && (cur_y == '0);
    eol  = (cur_x == geo_w - 14'd1);
    eof  = eol && (cur_y == geo_h - 32'd1);

    state_n = state;
    x_n     = x_r;
    y_n     = y_r;
    w_n     = w_r;
    h_n     = h_r;
    ct_n    = ct_r;
    ovf_n   = ovf_r;
    extra_n = extra_r;

    if (pstart) begin
      state_n = live ? ST_ACTIVE : ST_IDLE;
      ct_n    = colortype;
      ovf_n   = 1'b0;
      extra_n = 1'b0;
      if (live) begin
        w_n = width;
        h_n = height;
        x_n = '0;
        y_n = '0;
      end
    end

    // Position advances even when the FIFO drops the pixel, keeping tags aligned
    if (take) begin
      if (eol) begin
        x_n = '0;
        y_n = cur_y + 32'd1;
      end else begin
        x_n = cur_x + 14'd1;
      end
      if (eof) state_n = ST_IDLE;
      if (fifo_full && !fifo_pop) ovf_n = 1'b1;
    end

    if (pvalid && !live) extra_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      x_r     <= '0;
      y_r     <= '0;
      w_r     <= '0;
      h_r     <= '0;
      ct_r    <= '0;
      ovf_r   <= 1'b0;
      extra_r <= 1'b0;
    end else begin
      state   <= state_n;
      x_r     <= x_n;
      y_r     <= y_n;
      w_r     <= w_n;
      h_r     <= h_n;
      ct_r    <= ct_n;
      ovf_r   <= ovf_n;
      extra_r <= extra_n;
    end
  end

  assign fifo_din = {eof, eol, sof, pr, pg, pb, pa};
  assign fifo_pop = tvalid && tready;

  png_sync_fifo #(
    .W  (ENTRY_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (take),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs are forced quiet during reset, including the first reset cycle
  assign tvalid     = !rst && !fifo_empty;
  assign tdata      = tvalid ? fifo_dout[DATA_MSB:0] : 32'd0;
  assign tuser      = tvalid && fifo_dout[SOF_BIT];
  assign tlast      = tvalid && fifo_dout[EOL_BIT];
  assign teof       = tvalid && fifo_dout[EOF_BIT];
  assign ocolortype = rst ? 3'd0 : ct_r;
  assign busy       = !rst && (state == ST_ACTIVE);
  assign overflow   = !rst && ovf_r;
  assign extra      = !rst && extra_r;
endmodule

// File: tb/tb_png_pixel_framer.sv
// Directed bench for png_pixel_framer: framing tags, overflow, extra pixels and reset behaviour.
module tb_png_pixel_framer;
  logic        clk = 1'b0;
  logic        rst;
  logic        pstart;
  logic [2:0]  colortype;
  logic [13:0] width;
  logic [31:0] height;
  logic        pvalid;
  logic [7:0]  pr, pg, pb, pa;
  logic        tvalid, tready;
  logic [31:0] tdata;
  logic        tuser, tlast, teof;
  logic [2:0]  ocolortype;
  logic        busy, overflow, extra;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
    logic        e;
  } beat_t;
  beat_t beats[$];

  always #5 clk = ~clk;

  png_pixel_framer #(.FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .pstart(pstart), .colortype(colortype),
    .width(width), .height(height), .pvalid(pvalid),
    .pr(pr), .pg(pg), .pb(pb), .pa(pa),
    .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tuser(tuser), .tlast(tlast), .teof(teof),
    .ocolortype(ocolortype), .busy(busy), .overflow(overflow), .extra(extra)
  );

  // Inputs change just after posedge, so negedge values are the ones handshaken next edge
  always @(negedge clk) begin
    if (tvalid && tready) beats.push_back('{d: tdata, u: tuser, l: tlast, e: teof});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b + 8'h10, b + 8'h20, b + 8'h30};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [31:0] p);
    pvalid = 1'b1;
    {pr, pg, pb, pa} = p;
  endtask

  task automatic start(input logic [2:0] ct, input logic [13:0] w, input logic [31:0] h);
    pstart = 1'b1;
    colortype = ct;
    width = w;
    height = h;
  endtask

  initial begin
    rst = 1'b1; pstart = 1'b0; colortype = '0; width = '0; height = '0;
    pvalid = 1'b0; pr = '0; pg = '0; pb = '0; pa = '0; tready = 1'b1;
    tick(); tick();
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {29'd0, overflow, extra, tuser}, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_ct", 32'(ocolortype), 0);
    rst = 1'b0;
    tick();

    // 3x2 image, back-to-back pixels
    start(3'd6, 14'd3, 32'd2);
    tick();
    pstart = 1'b0;
    chk("t1_busy_start", 32'(busy), 1);
    chk("t1_ct", 32'(ocolortype), 6);
    for (int i = 0; i < 6; i++) begin
      set_pix(pix(i));
      tick();
      if (i == 0) chk("t1_fwft", 32'(tvalid), 1);
      if (i == 4) chk("t1_busy_mid", 32'(busy), 1);
    end
    pvalid = 1'b0;
    chk("t1_busy_end", 32'(busy), 0);
    tick(); tick(); tick();
    chk("t1_count", beats.size(), 6);
    for (int i = 0; i < 6 && i < beats.size(); i++) begin
      chk($sformatf("t1_data%0d", i), beats[i].d, pix(i));
      chk($sformatf("t1_tags%0d", i), {29'd0, beats[i].u, beats[i].l, beats[i].e},
          {29'd0, i == 0, i == 2 || i == 5, i == 5});
    end
    beats.delete();

    // 20 pixels into a 16-deep FIFO with the sink stalled
    tready = 1'b0;
    start(3'd2, 14'd20, 32'd1);
    tick();
    pstart = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_pix(pix(i + 64));
      tick();
    end
    pvalid = 1'b0;
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_busy", 32'(busy), 0);
    tick(); tick();
    chk("t2_hold_data", tdata, pix(64));
    chk("t2_hold_sof", 32'(tuser), 1);
    tready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("t2_count", beats.size(), 16);
    for (int i = 0; i < 16 && i < beats.size(); i++) begin
      chk($sformatf("t2_data%0d", i), beats[i].d, pix(i + 64));
      chk($sformatf("t2_tags%0d", i), {29'd0, beats[i].u, beats[i].l, beats[i].e},
          {29'd0, i == 0, 1'b0, 1'b0});
    end
    beats.delete();

    // pixels with no image open
    set_pix(pix(1)); tick();
    set_pix(pix(2)); tick();
    pvalid = 1'b0;
    tick();
    chk("t3_extra", 32'(extra), 1);
    chk("t3_tvalid", 32'(tvalid), 0);
    start(3'd0, 14'd2, 32'd1);
    tick();
    pstart = 1'b0;
    chk("t3_extra_clr", 32'(extra), 0);
    chk("t3_ovf_clr", 32'(overflow), 0);
    chk("t3_busy", 32'(busy), 1);

    // pstart and pixel in the same cycle, 1x1 image
    start(3'd4, 14'd1, 32'd1);
    set_pix(32'hA1B2C3D4);
    tick();
    pstart = 1'b0; pvalid = 1'b0;
    chk("t4_busy", 32'(busy), 0);
    tick(); tick();
    chk("t4_count", beats.size(), 1);
    if (beats.size() > 0) begin
      chk("t4_data", beats[0].d, 32'hA1B2C3D4);
      chk("t4_tags", {29'd0, beats[0].u, beats[0].l, beats[0].e}, 7);
    end
    beats.delete();

    // zero height
    start(3'd2, 14'd5, 32'd0);
    tick();
    pstart = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ct", 32'(ocolortype), 2);
    chk("t5_extra0", 32'(extra), 0);
    set_pix(pix(9)); tick();
    pvalid = 1'b0;
    chk("t5_extra", 32'(extra), 1);
    tick();
    chk("t5_tvalid", 32'(tvalid), 0);

    // reset with 5 entries queued
    tready = 1'b0;
    start(3'd3, 14'd10, 32'd1);
    tick();
    pstart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_pix(pix(i + 100));
      tick();
    end
    pvalid = 1'b0;
    chk("t6_tvalid_pre", 32'(tvalid), 1);
    chk("t6_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    tick();
    chk("t6_tvalid", 32'(tvalid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_flags", {27'd0, overflow, extra, tuser, tlast, teof}, 0);
    chk("t6_tdata", tdata, 0);
    chk("t6_ct", 32'(ocolortype), 0);
    rst = 1'b0;
    tready = 1'b1;
    tick();
    set_pix(pix(7)); tick();
    pvalid = 1'b0;
    chk("t6_extra", 32'(extra), 1);
    tick(); tick();
    chk("t6_tvalid_post", 32'(tvalid), 0);
    chk("t6_beats", beats.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/png_pixel_framer.md
PNG_PIXEL_FRAMER -- requirements
Module: png_pixel_framer

Interface
REQ-001 The module SHALL have parameter FIFO_AW, default 4, meaning output FIFO depth = 2^FIFO_AW entries.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, a synchronous, active-high reset.
REQ-004 The module SHALL have port pstart, input, 1 bit, a decoder image-start pulse carrying geometry.
REQ-005 The module SHALL have port colortype, input, 3 bits, the PNG color type, sampled on pstart.
REQ-006 The module SHALL have port width, input, 14 bits, pixels per line, sampled on pstart.
REQ-007 The module SHALL have port height, input, 32 bits, lines per image, sampled on pstart.
REQ-008 The module SHALL have port pvalid, input, 1 bit, a decoded pixel strobe; it has no backpressure.
REQ-009 The module SHALL have ports pr, pg, pb, pa, input, 8 bits each, the pixel channels valid with pvalid.
REQ-010 The module SHALL have port tvalid, output, 1 bit, output stream valid.
REQ-011 The module SHALL have port tready, input, 1 bit, output stream ready.
REQ-012 The module SHALL have port tdata, output, 32 bits, {r,g,b,a} with r in bits 31:24.
REQ-013 The module SHALL have port tuser, output, 1 bit, asserted with the first pixel of an image (SOF).
REQ-014 The module SHALL have port tlast, output, 1 bit, asserted with the last pixel of each line (EOL).
REQ-015 The module SHALL have port teof, output, 1 bit, asserted with the last pixel of the image.
REQ-016 The module SHALL have port ocolortype, output, 3 bits, the latched colortype of the current image.
REQ-017 The module SHALL have port busy, output, 1 bit, an image is active and not all pixels have been received.
REQ-018 The module SHALL have port overflow, output, 1 bit, sticky: a pixel was dropped because the FIFO was full.
REQ-019 The module SHALL have port extra, output, 1 bit, sticky: a pixel arrived while not busy.

Function
REQ-020 The FSM SHALL have states IDLE and ACTIVE; pstart with width!=0 and height!=0 SHALL move any state to ACTIVE with x=0, y=0 and latch geometry.
REQ-021 pstart with width==0 or height==0 SHALL go to IDLE, latch colortype and set nothing else.
REQ-022 In ACTIVE, each pvalid SHALL tag the pixel sof=(x==0&&y==0), eol=(x==W-1), eof=(eol&&y==H-1), then advance x.
REQ-023 At the end of a line, x SHALL wrap to 0 and y SHALL increment.
REQ-024 On eof, the FSM SHALL return to IDLE in the next cycle.
REQ-025 pvalid in the same cycle as pstart SHALL be the first pixel of the new image, using the new width and height.
REQ-026 pstart SHALL clear overflow and extra, and SHALL NOT flush the FIFO.
REQ-027 pvalid in IDLE (without pstart) SHALL drop the pixel and set extra.
REQ-028 pvalid in ACTIVE with the FIFO full SHALL drop the pixel, set overflow, and still advance x and y, so that framing tags stay aligned to image position.
REQ-029 A simultaneous FIFO pop (tvalid&&tready) and push when full SHALL accept the push (no overflow).
REQ-030 The FIFO SHALL be first-word-fall-through: a pixel pushed in cycle N with the FIFO empty SHALL give tvalid=1 in cycle N+1.
REQ-031 Sustained throughput SHALL be 1 pixel/cycle.
REQ-032 tdata, tuser, tlast and teof SHALL be held stable while tvalid&&!tready.
REQ-033 The y counter SHALL be 32 bits and the x counter 14 bits; y SHALL never wrap within a legal image.

Reset
REQ-034 While rst=1, the block SHALL be in IDLE with x=y=0, the FIFO empty, and tvalid, tuser, tlast, teof, busy, overflow, extra and ocolortype all 0.
REQ-035 tdata SHALL be 0 while rst=1.
REQ-036 Reset mid-image SHALL discard the FIFO contents; pixels arriving after rst deasserts and before any pstart SHALL set extra.

Structure
REQ-037 Package png_pkg SHALL hold the FIFO entry width (35 = 32 data + sof, eol, eof), the field bit indices and the FSM state encodings.
REQ-038 The FIFO SHALL be a sub-module png_sync_fifo (parameterised by width and FIFO_AW, with a full/empty count); the framing FSM and counters SHALL be in png_pixel_framer.

Verification
REQ-039 Bench test: width=3, height=2, 6 back-to-back pixels, tready=1 -> 6 beats; tuser on beat 0; tlast on beats 2 and 5; teof on beat 5 only; busy falls after the 6th pixel.
REQ-040 Bench test: tready=0, FIFO_AW=4, 20 pixels of an image of width=20, height=1 -> 16 stored; overflow=1; after tready=1, 16 beats, none with teof (the eof pixel was dropped).
REQ-041 Bench test: 2 pixels before any pstart -> extra=1, no tvalid; then pstart -> extra=0.
REQ-042 Bench test: pstart with height=0 -> busy stays 0; a following pixel sets extra.
REQ-043 Bench test: pstart and pvalid in the same cycle (width=1, height=1) -> one beat with tuser=tlast=teof=1, data equal to the input pixel.
REQ-044 Bench test: rst asserted mid-image with the FIFO holding 5 entries -> next cycle tvalid=0, busy=0, all flags 0.
